alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Pipeline stage that produces the ALU's input interface: `inputA`, `inputB` and the 3-bit `aluControl` opcode.
- Accepts a raw RV32I instruction plus register-file read data and decodes R-type and I-type ALU instructions into ALU operands and opcode.
- Registers the decoded result behind a valid/ready handshake, with a 2-entry skid buffer so throughput stays at one per cycle.
- Sits between register read and execute; its outputs drive the ALU directly.

Parameters:
- XLEN, 32, datapath width of operands and instruction.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  synchronous discard of all buffered entries
- inValid  input  1  upstream entry present
- inReady  output  1  stage can accept this cycle
- instr  input  XLEN  raw instruction word
- rs1Data  input  XLEN  register-file read data for rs1
- rs2Data  input  XLEN  register-file read data for rs2
- outValid  output  1  decoded entry present
- outReady  input  1  execute stage consumes this cycle
- inputA  output  XLEN  ALU operand A (rs1Data)
- inputB  output  XLEN  ALU operand B (rs2Data or sign-extended imm[11:0])
- aluControl  output  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 unsigned set-less-than
- rdAddr  output  5  destination register, instr[11:7]
- regWrite  output  1  write-back enable
- illegal  output  1  instruction not supported by this ALU

Behaviour:
- Transfers: accept = inValid & inReady; issue = outValid & outReady.
- Latency: an accepted entry appears on the outputs the next cycle.
- Decode, opcode 0110011 (R-type):
  - funct3 000 with funct7 0000000 -> ADD; with funct7 0100000 -> SUB.
  - funct3 111 -> AND; 110 -> OR; 100 -> XOR; 011 (SLTU) -> 101.
  - R-type logic ops and SLTU require funct7 = 0.
- Decode, opcode 0010011 (I-type): funct3 000/111/110/100/011 -> ADD/AND/OR/XOR/101; inputB = {{20{instr[31]}}, instr[31:20]}.
- Illegal entries:
  - Covers funct3 010 (SLT/SLTI, signed compare unsupported), shifts (001, 101), any other opcode, and a bad funct7.
  - Output: illegal=1, regWrite=0, aluControl=000, inputB=rs2Data; still flows through the handshake.
- regWrite = legal & (rdAddr != 0).
- Skid FSM states and transitions:
  - EMPTY: accept -> ONE.
  - ONE: accept & !issue -> TWO (new entry to skid register); accept & issue -> ONE (main reloads); !accept & issue -> EMPTY.
  - TWO: inReady=0; issue -> ONE (skid moves to main, in order).
- Register rules:
  - inReady is registered: 1 in EMPTY/ONE, 0 in TWO.
  - Outputs come only from the main register; never combinational from inputs.
  - Payload registers hold their value while outValid=1 & outReady=0.
- flush: next state EMPTY. Flush overrides a same-cycle accept; that entry is dropped. Issue in the flush cycle still counts.
- rst: state EMPTY, outValid=0, inReady=0 during reset, inReady=1 the first cycle after. All payload outputs reset to 0 (aluControl=000, illegal=0, regWrite=0). Reset mid-stream drops all entries.
- inValid dropping without acceptance is legal; no entry is recorded.

Decomposition:
- Package alu_pkg:
  - ALU opcode localparams ALU_ADD..ALU_SLTU (3'b000..3'b101).
  - OPC_OP=7'b0110011, OPC_OPIMM=7'b0010011.
  - funct3/funct7 constants.
  - Packed struct alu_issue_t {inputA, inputB, aluControl, rdAddr, regWrite, illegal}, used for the main and skid registers.
- Sub-module alu_op_decoder: purely combinational, maps instr/rs1Data/rs2Data to alu_issue_t. The top holds the skid FSM and the two struct registers.

Test Plan:
- ADD: instr=0x002081B3, rs1Data=5, rs2Data=7, outReady=1 -> next cycle outValid=1, aluControl=000, inputA=5, inputB=7, rdAddr=3, regWrite=1, illegal=0.
- SUB and ADDI back-to-back:
  - instr=0x402081B3 (SUB) -> aluControl=001.
  - Then instr=0xFFF00293 (ADDI x5,x0,-1), rs1Data=0 -> inputB=0xFFFFFFFF, aluControl=000, rdAddr=5.
  - Both accepted on consecutive cycles with inReady held at 1.
- Unsigned compare and immediate AND:
  - instr=0x0020B233 (SLTU) -> aluControl=101, regWrite=1.
  - instr=0x0020A233 (SLT) -> illegal=1, regWrite=0, aluControl=000.
  - instr=0x0F00F313 (ANDI) -> aluControl=010, inputB=0x000000F0.
- Backpressure:
  - Stream 4 ADDs with outReady=0 -> 2 accepted, inReady=0 after the second; outputs hold entry 1.
  - Raise outReady -> entries issue in order 1,2,3,4 with no loss or duplication.
- Flush in state TWO together with inValid=1 -> next cycle outValid=0, inReady=1; the concurrent entry does not appear.
- rst asserted mid-stream with outValid=1 -> next cycle outValid=0, inReady=0, aluControl=000. After release, inReady=1 and the first new entry issues normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and encodings for the ALU issue stage: opcode/funct constants,
// ALU control codes and the decoded-entry struct held in the skid registers.
package alu_pkg;

    localparam int ALU_XLEN = 32;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLTU = 3'b101;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [ALU_XLEN-1:0] inputA;
        logic [ALU_XLEN-1:0] inputB;
        logic [2:0]          aluControl;
        logic [4:0]          rdAddr;
        logic                regWrite;
        logic                illegal;
    } alu_issue_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_ONE   = 2'b01,
        SKID_TWO   = 2'b10
    } skid_state_t;

    function automatic logic [ALU_XLEN-1:0] sext_imm12(input logic [11:0] imm);
        return {{(ALU_XLEN-12){imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/alu_issue_stage_decoder.sv
// Combinational RV32I decoder for the ALU subset: R-type/I-type arithmetic and
// logic ops become operands plus a 3-bit ALU control; everything else is illegal.
module alu_op_decoder
    import alu_pkg::*;
(
    input  logic [ALU_XLEN-1:0] i_instr,
    input  logic [ALU_XLEN-1:0] i_rs1_data,
    input  logic [ALU_XLEN-1:0] i_rs2_data,
    output alu_issue_t          o_issue
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic [4:0] w_rd;
    logic       w_legal;
    logic       w_use_imm;
    logic [2:0] w_op;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_funct7 = i_instr[31:25];
    assign w_rd     = i_instr[11:7];

    always_comb begin
        w_legal   = 1'b0;
        w_use_imm = 1'b0;
        w_op      = ALU_ADD;
        case (w_opcode)
            OPC_OP: begin
                case (w_funct3)
                    F3_ADD: begin
                        if (w_funct7 == F7_BASE) begin
                            w_legal = 1'b1;
                            w_op    = ALU_ADD;
                        end else if (w_funct7 == F7_ALT) begin
                            w_legal = 1'b1;
                            w_op    = ALU_SUB;
                        end
                    end
                    F3_AND: begin
                        w_legal = (w_funct7 == F7_BASE);
                        w_op    = ALU_AND;
                    end
                    F3_OR: begin
                        w_legal = (w_funct7 == F7_BASE);
                        w_op    = ALU_OR;
                    end
                    F3_XOR: begin
                        w_legal = (w_funct7 == F7_BASE);
                        w_op    = ALU_XOR;
                    end
                    F3_SLTU: begin
                        w_legal = (w_funct7 == F7_BASE);
                        w_op    = ALU_SLTU;
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            OPC_OPIMM: begin
                w_use_imm = 1'b1;
                case (w_funct3)
                    F3_ADD: begin
                        w_legal = 1'b1;
                        w_op    = ALU_ADD;
                    end
                    F3_AND: begin
                        w_legal = 1'b1;
                        w_op    = ALU_AND;
                    end
                    F3_OR: begin
                        w_legal = 1'b1;
                        w_op    = ALU_OR;
                    end
                    F3_XOR: begin
                        w_legal = 1'b1;
                        w_op    = ALU_XOR;
                    end
                    F3_SLTU: begin
                        w_legal = 1'b1;
                        w_op    = ALU_SLTU;
                    end
                    // SLTI (signed) and the shift-immediates have no ALU support here
                    default: w_legal = 1'b0;
                endcase
            end
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        o_issue            = '0;
        o_issue.inputA     = i_rs1_data;
        o_issue.inputB     = (w_legal && w_use_imm) ? sext_imm12(i_instr[31:20]) : i_rs2_data;
        o_issue.aluControl = w_legal ? w_op : ALU_ADD;
        o_issue.rdAddr     = w_rd;
        o_issue.regWrite   = w_legal && (w_rd != 5'd0);
        o_issue.illegal    = !w_legal;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes one instruction per cycle into ALU operands and holds
// results in a main register backed by a skid register for full-rate handshaking.
//
// state | meaning
// EMPTY | no entry held, outValid=0
// ONE   | main register valid, skid free
// TWO   | main and skid valid, upstream stalled
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int XLEN = ALU_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            inValid,
    output logic            inReady,
    input  logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] rs1Data,
    input  logic [XLEN-1:0] rs2Data,
    output logic            outValid,
    input  logic            outReady,
    output logic [XLEN-1:0] inputA,
    output logic [XLEN-1:0] inputB,
    output logic [2:0]      aluControl,
    output logic [4:0]      rdAddr,
    output logic            regWrite,
    output logic            illegal
);

    skid_state_t r_state;
    skid_state_t w_state_nxt;
    alu_issue_t  r_main;
    alu_issue_t  r_skid;
    alu_issue_t  w_dec;
    logic        r_in_ready;
    logic        w_out_valid;
    logic        w_accept;
    logic        w_issue;
    logic        w_load_main_dec;
    logic        w_load_main_skid;
    logic        w_load_skid;

    alu_op_decoder u_decoder (
        .i_instr    (instr),
        .i_rs1_data (rs1Data),
        .i_rs2_data (rs2Data),
        .o_issue    (w_dec)
    );

    assign w_out_valid = (r_state != SKID_EMPTY);
    assign w_accept    = inValid && r_in_ready;
    assign w_issue     = w_out_valid && outReady;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_dec  = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            SKID_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt     = SKID_ONE;
                    w_load_main_dec = 1'b1;
                end
            end
            SKID_ONE: begin
                if (w_accept && w_issue) begin
                    w_load_main_dec = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = SKID_TWO;
                    w_load_skid = 1'b1;
                end else if (w_issue) begin
                    w_state_nxt = SKID_EMPTY;
                end
            end
            SKID_TWO: begin
                if (w_issue) begin
                    w_state_nxt      = SKID_ONE;
                    w_load_main_skid = 1'b1;
                end
            end
            default: w_state_nxt = SKID_EMPTY;
        endcase
        // Flush wins over a same-cycle accept; an issue this cycle has already completed.
        if (flush) begin
            w_state_nxt      = SKID_EMPTY;
            w_load_main_dec  = 1'b0;
            w_load_main_skid = 1'b0;
            w_load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= SKID_EMPTY;
            r_in_ready <= 1'b0;
            r_main     <= '0;
            r_skid     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != SKID_TWO);
            if (w_load_main_dec) begin
                r_main <= w_dec;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_dec;
            end
        end
    end

    assign inReady    = r_in_ready;
    assign outValid   = w_out_valid;
    assign inputA     = r_main.inputA;
    assign inputB     = r_main.inputB;
    assign aluControl = r_main.aluControl;
    assign rdAddr     = r_main.rdAddr;
    assign regWrite   = r_main.regWrite;
    assign illegal    = r_main.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed handshake/decode scenarios plus a random
// stream, with a scoreboard fed at accept time and drained at issue time.
module tb_alu_issue_stage;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            inValid;
    logic            inReady;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] rs1Data;
    logic [XLEN-1:0] rs2Data;
    logic            outValid;
    logic            outReady;
    logic [XLEN-1:0] inputA;
    logic [XLEN-1:0] inputB;
    logic [2:0]      aluControl;
    logic [4:0]      rdAddr;
    logic            regWrite;
    logic            illegal;

    alu_issue_stage #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .inValid    (inValid),
        .inReady    (inReady),
        .instr      (instr),
        .rs1Data    (rs1Data),
        .rs2Data    (rs2Data),
        .outValid   (outValid),
        .outReady   (outReady),
        .inputA     (inputA),
        .inputB     (inputB),
        .aluControl (aluControl),
        .rdAddr     (rdAddr),
        .regWrite   (regWrite),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  ctl;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_vec    = 0;
    int   n_err    = 0;
    int   n_issued = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: what the ISA says each supported mnemonic should produce.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        exp_t       e;
        int         op;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        opc = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        op  = -1;
        if (opc == 7'b0110011) begin
            if (f3 == 3'd0 && f7 == 7'h00)      op = 0;
            else if (f3 == 3'd0 && f7 == 7'h20) op = 1;
            else if (f7 == 7'h00) begin
                if (f3 == 3'd7)      op = 2;
                else if (f3 == 3'd6) op = 3;
                else if (f3 == 3'd4) op = 4;
                else if (f3 == 3'd3) op = 5;
            end
        end else if (opc == 7'b0010011) begin
            if (f3 == 3'd0)      op = 0;
            else if (f3 == 3'd7) op = 2;
            else if (f3 == 3'd6) op = 3;
            else if (f3 == 3'd4) op = 4;
            else if (f3 == 3'd3) op = 5;
        end
        e.a   = a;
        e.ill = (op < 0);
        e.ctl = e.ill ? 3'd0 : 3'(op);
        e.b   = (!e.ill && opc == 7'b0010011) ? {{20{ins[31]}}, ins[31:20]} : b;
        e.rd  = ins[11:7];
        e.we  = !e.ill && (ins[11:7] != 5'd0);
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] opc;
        logic [6:0] f7;
        logic [2:0] f3;
        logic [4:0] rd;
        case ($urandom_range(0, 4))
            0, 1:    opc = 7'b0110011;
            2, 3:    opc = 7'b0010011;
            default: opc = 7'($urandom);
        endcase
        case ($urandom_range(0, 3))
            0, 1:    f7 = 7'h00;
            2:       f7 = 7'h20;
            default: f7 = 7'($urandom);
        endcase
        f3 = 3'($urandom);
        rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        return {f7, 5'($urandom), 5'($urandom), f3, rd, opc};
    endfunction

    // Monitor first (issue this cycle), then flush/reset purge, then record accept.
    always @(negedge clk) begin
        if (!rst && outValid && outReady) begin
            n_issued++;
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_unexpected: got issue with inputA 0x%08h expected no entry", inputA);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_inputA", inputA, mon_e.a);
                chk("sb_inputB", inputB, mon_e.b);
                chk("sb_aluControl", 32'(aluControl), 32'(mon_e.ctl));
                chk("sb_rdAddr", 32'(rdAddr), 32'(mon_e.rd));
                chk("sb_regWrite", 32'(regWrite), 32'(mon_e.we));
                chk("sb_illegal", 32'(illegal), 32'(mon_e.ill));
            end
        end
        if (rst || flush) sb_q.delete();
        else if (inValid && inReady) sb_q.push_back(model(instr, rs1Data, rs2Data));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        logic ok;
        ok      = 1'b0;
        inValid = 1'b1;
        instr   = ins;
        rs1Data = a;
        rs2Data = b;
        for (int i = 0; i < 50; i++) begin
            ok = inReady;
            step();
            if (ok) break;
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: got inReady=0 for 50 cycles expected acceptance");
        end
        inValid = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        outReady = 1'b1;
        inValid  = 1'b0;
        flush    = 1'b0;
        k = 0;
        while ((outValid || sb_q.size() != 0) && k < 40) begin
            step();
            k++;
        end
        chk({name, "_queue_empty"}, 32'(sb_q.size()), 32'd0);
        chk({name, "_outValid"}, 32'(outValid), 32'd0);
    endtask

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_ADDI = 32'hFFF00293;
    localparam logic [31:0] I_SLTU = 32'h0020B233;
    localparam logic [31:0] I_SLT  = 32'h0020A233;
    localparam logic [31:0] I_ANDI = 32'h0F00F313;

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int issued0;
        rst = 1'b1; flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
        instr = '0; rs1Data = '0; rs2Data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outValid", 32'(outValid), 32'd0);
        chk("rst_inReady", 32'(inReady), 32'd0);
        chk("rst_aluControl", 32'(aluControl), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_regWrite", 32'(regWrite), 32'd0);
        chk("rst_inputA", inputA, 32'd0);
        rst = 1'b0;
        step();
        chk("post_rst_inReady", 32'(inReady), 32'd1);
        chk("post_rst_outValid", 32'(outValid), 32'd0);

        // Decode examples, back to back
        outReady = 1'b1;
        send(I_ADD, 32'd5, 32'd7);
        chk("add_outValid", 32'(outValid), 32'd1);
        chk("add_aluControl", 32'(aluControl), 32'd0);
        chk("add_inputA", inputA, 32'd5);
        chk("add_inputB", inputB, 32'd7);
        chk("add_rdAddr", 32'(rdAddr), 32'd3);
        chk("add_regWrite", 32'(regWrite), 32'd1);
        chk("add_illegal", 32'(illegal), 32'd0);
        send(I_SUB, 32'd9, 32'd4);
        chk("sub_aluControl", 32'(aluControl), 32'd1);
        chk("sub_inReady", 32'(inReady), 32'd1);
        send(I_ADDI, 32'd0, 32'h1234);
        chk("addi_inputB", inputB, 32'hFFFFFFFF);
        chk("addi_aluControl", 32'(aluControl), 32'd0);
        chk("addi_rdAddr", 32'(rdAddr), 32'd5);
        chk("addi_inReady", 32'(inReady), 32'd1);
        send(I_SLTU, 32'd3, 32'd8);
        chk("sltu_aluControl", 32'(aluControl), 32'd5);
        chk("sltu_regWrite", 32'(regWrite), 32'd1);
        send(I_SLT, 32'd3, 32'd8);
        chk("slt_illegal", 32'(illegal), 32'd1);
        chk("slt_regWrite", 32'(regWrite), 32'd0);
        chk("slt_aluControl", 32'(aluControl), 32'd0);
        chk("slt_inputB", inputB, 32'd8);
        send(I_ANDI, 32'd1, 32'd2);
        chk("andi_aluControl", 32'(aluControl), 32'd2);
        chk("andi_inputB", inputB, 32'h000000F0);
        step();
        chk("idle_outValid", 32'(outValid), 32'd0);

        // Backpressure: two fill, third stalls, then release in order
        issued0  = n_issued;
        outReady = 1'b0;
        send(I_ADD, 32'd101, 32'd1);
        send(I_ADD, 32'd102, 32'd2);
        chk("bp_inReady_full", 32'(inReady), 32'd0);
        chk("bp_outValid", 32'(outValid), 32'd1);
        inValid = 1'b1; instr = I_ADD; rs1Data = 32'd103; rs2Data = 32'd3;
        repeat (3) step();
        chk("bp_hold_inputA", inputA, 32'd101);
        chk("bp_hold_inReady", 32'(inReady), 32'd0);
        outReady = 1'b1;
        send(I_ADD, 32'd103, 32'd3);
        send(I_ADD, 32'd104, 32'd4);
        drain("bp");
        chk("bp_issue_count", 32'(n_issued - issued0), 32'd4);

        // Flush while full, with a concurrent offer
        outReady = 1'b0;
        send(I_ADD, 32'd201, 32'd1);
        send(I_ADD, 32'd202, 32'd2);
        chk("fl_inReady_full", 32'(inReady), 32'd0);
        inValid = 1'b1; instr = I_ADD; rs1Data = 32'd203; flush = 1'b1;
        step();
        flush = 1'b0; inValid = 1'b0;
        chk("fl_outValid", 32'(outValid), 32'd0);
        chk("fl_inReady", 32'(inReady), 32'd1);
        step();
        chk("fl_dropped_outValid", 32'(outValid), 32'd0);

        // Reset mid-stream
        send(I_SUB, 32'd301, 32'd1);
        chk("mr_outValid_before", 32'(outValid), 32'd1);
        rst = 1'b1;
        step();
        chk("mr_outValid", 32'(outValid), 32'd0);
        chk("mr_inReady", 32'(inReady), 32'd0);
        chk("mr_aluControl", 32'(aluControl), 32'd0);
        chk("mr_inputA", inputA, 32'd0);
        rst = 1'b0;
        step();
        chk("mr_post_inReady", 32'(inReady), 32'd1);
        outReady = 1'b1;
        send(I_ADD, 32'd11, 32'd22);
        chk("mr_new_outValid", 32'(outValid), 32'd1);
        chk("mr_new_inputA", inputA, 32'd11);
        drain("mr");

        // Random traffic with random backpressure and occasional flush
        for (int c = 0; c < 800; c++) begin
            inValid  = ($urandom_range(0, 9) < 7);
            outReady = ($urandom_range(0, 9) < 6);
            flush    = ($urandom_range(0, 49) == 0);
            instr    = rand_instr();
            rs1Data  = $urandom;
            rs2Data  = $urandom;
            step();
        end
        drain("rnd");
        chk("rnd_some_issued", 32'(n_issued > 100), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
